// File: rtl/input_pack_mem_pkg.sv
// Shared definitions for the frame memory byte packer and fetch blocks.
// Holds frame geometry, FSM states and the byte-lane offset helper.
package input_pack_mem_pkg;

    localparam int FRAME_WORDS    = 19200;
    localparam int BYTES_PER_WORD = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Byte k of a group occupies bits [lsb+7:lsb] with lsb = 120 - 8k.
    function automatic logic [6:0] lane_lsb(input logic [3:0] k);
        return 7'(120 - 8 * int'(k));
    endfunction

endpackage

// File: rtl/input_pack_mem_byte_packer.sv
// Collects 16 bytes into a 128-bit word, first byte in the top lane.
// Ports: clear_i drops a partial word, accept_i takes byte_i, word_valid_o/word_o flag a full word.
module input_pack_mem_byte_packer
    import input_pack_mem_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear_i,
    input  logic         accept_i,
    input  logic [7:0]   byte_i,
    output logic         word_valid_o,
    output logic [127:0] word_o
);

    logic [127:0] sr_q, sr_d;
    logic [3:0]   cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (accept_i) begin
            sr_d[lane_lsb(cnt_q) +: 8] = byte_i;
            cnt_d = cnt_q + 4'd1;
        end
    end

    // The last byte bypasses the register so the word is ready on its own edge.
    assign word_valid_o = accept_i && !clear_i && (cnt_q == 4'd15);
    assign word_o       = {sr_q[127:8], byte_i};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/input_pack_mem.sv
// Packs a byte stream into 128-bit words and writes one frame into memory.
// Ports: start/DataIn/DataValid/input_base_offset in; WriteBus/WriteAddress/WriteEnable/done out.
module input_pack_mem
    import input_pack_mem_pkg::*;
#(
    parameter int WORDS          = FRAME_WORDS,
    parameter int ADDR_W         = 16,
    parameter int BYTES_PER_WORD = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [15:0]                 DataIn,
    input  logic                        DataValid,
    input  logic                        input_base_offset,
    output logic [8*BYTES_PER_WORD-1:0] WriteBus,
    output logic [ADDR_W-1:0]           WriteAddress,
    output logic                        WriteEnable,
    output logic                        done
);

    localparam int IDX_W  = ADDR_W - 1;
    localparam int WORD_W = 8 * BYTES_PER_WORD;

    state_e             state_q, state_d;
    logic               base_q, base_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;
    logic               we_q, we_d;
    logic [WORD_W-1:0]  wbus_q, wbus_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic               accept;
    logic               clear;
    logic               word_valid;
    logic [127:0]       word;
    logic               unused_hi;

    assign unused_hi = ^DataIn[15:8];

    // Once the final word is packed, further bytes are not taken.
    assign accept = DataValid && start && (state_q == ST_FILL) && !last_q;
    assign clear  = (state_q != ST_FILL) || !start;

    input_pack_mem_byte_packer u_packer (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear_i      (clear),
        .accept_i     (accept),
        .byte_i       (DataIn[7:0]),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        idx_d   = idx_q;
        last_d  = last_q;
        we_d    = 1'b0;
        wbus_d  = wbus_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_IDLE: begin
                base_d = input_base_offset;
                addr_d = {input_base_offset, {IDX_W{1'b0}}};
                idx_d  = '0;
                last_d = 1'b0;
                if (start) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (word_valid) begin
                    wbus_d = WORD_W'(word);
                    we_d   = 1'b1;
                    addr_d = {base_q, idx_q};
                    if (idx_q == IDX_W'(WORDS - 1)) last_d = 1'b1;
                    else idx_d = idx_q + 1'b1;
                end
                if (!start) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    last_d  = 1'b0;
                end else if (we_q && last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            base_q  <= 1'b0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            wbus_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            we_q    <= we_d;
            wbus_q  <= wbus_d;
            addr_q  <= addr_d;
        end
    end

    assign WriteBus     = wbus_q;
    assign WriteAddress = addr_q;
    assign WriteEnable  = we_q;
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_input_pack_mem.sv
// Randomized bench for input_pack_mem against a byte-group reference model.
// Uses a short frame so a complete frame fits in a brief run.
module tb_input_pack_mem;

    localparam int WORDS = 20;

    logic         clock;
    logic         reset_n;
    logic         start;
    logic [15:0]  DataIn;
    logic         DataValid;
    logic         input_base_offset;
    logic [127:0] WriteBus;
    logic [15:0]  WriteAddress;
    logic         WriteEnable;
    logic         done;

    input_pack_mem #(.WORDS(WORDS)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .DataIn            (DataIn),
        .DataValid         (DataValid),
        .input_base_offset (input_base_offset),
        .WriteBus          (WriteBus),
        .WriteAddress      (WriteAddress),
        .WriteEnable       (WriteEnable),
        .done              (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0]  addr;
        logic [127:0] data;
        bit           last;
    } wr_t;

    wr_t          exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           n_wr = 0;
    int           we_cyc = 0;
    int           we_cyc_prev = 0;
    logic [15:0]  last_addr = '0;
    logic [127:0] last_bus = '0;
    bit           after_last = 0;

    // Reference model: bytes of the current group, word count, frame base.
    bit           m_on = 0;
    bit           m_base = 0;
    logic [7:0]   m_bytes[$];
    int           m_widx = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (reset_n) begin
            if (after_last) begin
                check("done_rise", 128'(done), 128'(1));
                after_last = 0;
            end
            if (WriteEnable) begin
                wr_t e;
                check("done_in_we", 128'(done), 128'(0));
                n_wr++;
                last_addr   = WriteAddress;
                last_bus    = WriteBus;
                we_cyc_prev = we_cyc;
                we_cyc      = cyc;
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 128'(WriteAddress), 128'(e.addr));
                    check("wr_data", WriteBus, e.data);
                    if (e.last) after_last = 1;
                end
            end
        end
    end

    task automatic tick(input logic v, input logic [7:0] b);
        logic [127:0] w;
        wr_t e;
        DataValid = v;
        DataIn    = {8'($urandom), b};
        if (v && m_on && start) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 16) begin
                w = '0;
                for (int k = 0; k < 16; k++)
                    w = w + (128'(m_bytes[k]) << (8 * (15 - k)));
                e.addr = {m_base, 15'(m_widx)};
                e.data = w;
                e.last = (m_widx == WORDS - 1);
                exp_q.push_back(e);
                m_bytes.delete();
                m_widx++;
                if (m_widx == WORDS) m_on = 0;
            end
        end
        @(negedge clock);
    endtask

    task automatic start_frame(input bit b);
        start = 1'b1;
        input_base_offset = b;
        tick(1'b0, 8'h00);
        m_base = b;
        m_widx = 0;
        m_bytes.delete();
        m_on = 1;
    endtask

    task automatic abort_frame();
        m_on = 0;
        m_bytes.delete();
        m_widx = 0;
        start = 1'b0;
        tick(1'($urandom), 8'($urandom));
    endtask

    initial begin
        int n0;
        int guard;
        reset_n = 1'b0;
        start = 1'b0;
        input_base_offset = 1'b1;
        DataValid = 1'b0;
        DataIn = '0;
        repeat (3) @(negedge clock);
        check("rst_addr", 128'(WriteAddress), 128'(0));
        check("rst_we", 128'(WriteEnable), 128'(0));
        check("rst_bus", WriteBus, 128'(0));
        check("rst_done", 128'(done), 128'(0));
        reset_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("idle_addr", 128'(WriteAddress), 128'(16'h8000));
        check("idle_we", 128'(WriteEnable), 128'(0));
        check("idle_bus", WriteBus, 128'(0));
        check("idle_done", 128'(done), 128'(0));

        start_frame(1'b0);
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i));
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        check("ramp_bus", last_bus, 128'h000102030405060708090A0B0C0D0E0F);
        check("ramp_addr", 128'(last_addr), 128'(0));
        check("ramp_cnt", 128'(n_wr), 128'(1));

        abort_frame();
        start_frame(1'b0);
        for (int i = 0; i < 32; i++) tick(1'b1, 8'($urandom));
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        check("b2b_gap", 128'(we_cyc - we_cyc_prev), 128'(16));
        check("b2b_addr", 128'(last_addr), 128'(1));
        check("b2b_cnt", 128'(n_wr), 128'(3));

        abort_frame();
        start_frame(1'b0);
        for (int i = 0; i < 26; i++) tick(1'b1, 8'($urandom));
        n0 = n_wr;
        abort_frame();
        tick(1'b0, 8'h00);
        check("abort_nowr", 128'(n_wr), 128'(n0));
        start_frame(1'b0);
        for (int i = 0; i < 16; i++) tick(1'b1, 8'($urandom));
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        check("restart_addr", 128'(last_addr), 128'(0));
        check("restart_cnt", 128'(n_wr), 128'(n0 + 1));

        abort_frame();
        start_frame(1'b0);
        n0 = n_wr;
        for (int i = 0; i < 32; i++) tick(1'((i % 2) == 0), 8'($urandom));
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        check("toggle_cnt", 128'(n_wr), 128'(n0 + 1));
        check("toggle_addr", 128'(last_addr), 128'(0));

        abort_frame();
        start_frame(1'b1);
        guard = 0;
        while (m_on && guard < 5000) begin
            tick(1'(($urandom % 4) != 0), 8'($urandom));
            guard++;
        end
        check("frame_timeout", 128'(m_on), 128'(0));
        for (int i = 0; i < 10; i++) tick(1'b1, 8'($urandom));
        check("frame_done_hold", 128'(done), 128'(1));
        check("frame_last_addr", 128'(last_addr), 128'(16'h8013));
        check("frame_pending", 128'(exp_q.size()), 128'(0));
        check("total_writes", 128'(n_wr), 128'(26));
        start = 1'b0;
        tick(1'b0, 8'h00);
        check("done_clear", 128'(done), 128'(0));
        tick(1'b0, 8'h00);
        check("idle_again", 128'(WriteAddress), 128'(16'h8000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
